// File: rtl/l2_axi_bridge.sv
// L2 mem-port responder: refills, writebacks and uncached accesses run as AXI4 bursts with a posted write buffer.
// Read-after-write line check is built only when L2AXI_RAW_CHECK_EN is defined.
module l2_axi_bridge #(
  parameter  int OFFSET_WIDTH = 3,
  localparam int LINE_W       = 32 * (1 << OFFSET_WIDTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       addr_r,
  input  logic [31:0]       addr_w,
  input  logic [LINE_W-1:0] din_line,
  input  logic              req_r,
  input  logic              req_w,
  input  logic              rdy,
  input  logic              suc,
  input  logic [3:0]        wstrb,
  input  logic [1:0]        size,
  output logic              addrok_r,
  output logic              addrok_w,
  output logic              dataok,
  output logic [LINE_W-1:0] dout_line,
  output logic [31:0]       araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [31:0]       awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb_o,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  localparam int         WORDS     = 1 << OFFSET_WIDTH;
  localparam int         LA        = OFFSET_WIDTH + 2;
  localparam logic [7:0] BURST_LEN = 8'(WORDS - 1);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} w_state_e;

  r_state_e                      r_state_q, r_state_d;
  logic [31:0]                   ar_addr_q, ar_addr_d;
  logic [7:0]                    ar_len_q, ar_len_d;
  logic [2:0]                    ar_size_q, ar_size_d;
  logic [1:0]                    ar_burst_q, ar_burst_d;
  logic [WORDS-1:0][31:0]        rbuf_q, rbuf_d;
  logic [OFFSET_WIDTH-1:0]       r_beat_q, r_beat_d;

  w_state_e                      w_state_q, w_state_d;
  logic [31:0]                   aw_addr_q, aw_addr_d;
  logic [7:0]                    aw_len_q, aw_len_d;
  logic [2:0]                    aw_size_q, aw_size_d;
  logic [1:0]                    aw_burst_q, aw_burst_d;
  logic [WORDS-1:0][31:0]        wbuf_q, wbuf_d;
  logic [3:0]                    w_strb_q, w_strb_d;
  logic [OFFSET_WIDTH-1:0]       w_beat_q, w_beat_d;

  logic raw_hazard;

`ifdef L2AXI_RAW_CHECK_EN
  // A write being accepted this cycle already counts, so a same-line read loses the tie.
  logic w_busy_hit, w_accept_hit;
  assign w_busy_hit   = (w_state_q != W_IDLE) && (aw_addr_q[31:LA] == addr_r[31:LA]);
  assign w_accept_hit = (w_state_q == W_IDLE) && req_w && (addr_w[31:LA] == addr_r[31:LA]);
  assign raw_hazard   = w_busy_hit || w_accept_hit;
`else
  assign raw_hazard = 1'b0;
`endif

  assign addrok_r  = rstn && (r_state_q == R_IDLE) && req_r && !raw_hazard;
  assign addrok_w  = rstn && (w_state_q == W_IDLE) && req_w;

  assign arvalid   = (r_state_q == R_AR);
  assign araddr    = ar_addr_q;
  assign arlen     = ar_len_q;
  assign arsize    = ar_size_q;
  assign arburst   = ar_burst_q;
  assign rready    = (r_state_q == R_DATA);
  assign dataok    = (r_state_q == R_RESP);
  assign dout_line = rbuf_q;

  assign awvalid   = (w_state_q == W_AW);
  assign awaddr    = aw_addr_q;
  assign awlen     = aw_len_q;
  assign awsize    = aw_size_q;
  assign awburst   = aw_burst_q;
  assign wvalid    = (w_state_q == W_DATA);
  assign wdata     = wvalid ? wbuf_q[w_beat_q] : 32'd0;
  assign wstrb_o   = wvalid ? w_strb_q : 4'd0;
  assign wlast     = wvalid && (w_beat_q == aw_len_q[OFFSET_WIDTH-1:0]);
  assign bready    = (w_state_q == W_B);

  always_comb begin
    r_state_d  = r_state_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    rbuf_d     = rbuf_q;
    r_beat_d   = r_beat_q;
    case (r_state_q)
      R_IDLE: begin
        if (addrok_r) begin
          r_state_d  = R_AR;
          rbuf_d     = '0;
          r_beat_d   = '0;
          ar_burst_d = 2'b01;
          if (suc) begin
            ar_addr_d = addr_r;
            ar_len_d  = 8'd0;
            ar_size_d = {1'b0, size};
          end else begin
            ar_addr_d = {addr_r[31:LA], {LA{1'b0}}};
            ar_len_d  = BURST_LEN;
            ar_size_d = 3'd2;
          end
        end
      end
      R_AR:   if (arready) r_state_d = R_DATA;
      R_DATA: begin
        // rlast ends the burst; the counter only picks the destination word.
        if (rvalid) begin
          rbuf_d[r_beat_q] = rdata;
          r_beat_d         = r_beat_q + 1'b1;
          if (rlast) r_state_d = R_RESP;
        end
      end
      R_RESP: if (rdy) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state_q  <= R_IDLE;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      rbuf_q     <= '0;
      r_beat_q   <= '0;
    end else begin
      r_state_q  <= r_state_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      rbuf_q     <= rbuf_d;
      r_beat_q   <= r_beat_d;
    end
  end

  always_comb begin
    w_state_d  = w_state_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    wbuf_d     = wbuf_q;
    w_strb_d   = w_strb_q;
    w_beat_d   = w_beat_q;
    case (w_state_q)
      W_IDLE: begin
        if (addrok_w) begin
          w_state_d  = W_AW;
          wbuf_d     = din_line;
          w_beat_d   = '0;
          aw_burst_d = 2'b01;
          if (suc) begin
            aw_addr_d = addr_w;
            aw_len_d  = 8'd0;
            aw_size_d = {1'b0, size};
            w_strb_d  = wstrb;
          end else begin
            aw_addr_d = {addr_w[31:LA], {LA{1'b0}}};
            aw_len_d  = BURST_LEN;
            aw_size_d = 3'd2;
            w_strb_d  = 4'hF;
          end
        end
      end
      W_AW:   if (awready) w_state_d = W_DATA;
      W_DATA: begin
        if (wready) begin
          if (wlast) w_state_d = W_B;
          else       w_beat_d  = w_beat_q + 1'b1;
        end
      end
      W_B:    if (bvalid) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state_q  <= W_IDLE;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      wbuf_q     <= '0;
      w_strb_q   <= '0;
      w_beat_q   <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      wbuf_q     <= wbuf_d;
      w_strb_q   <= w_strb_d;
      w_beat_q   <= w_beat_d;
    end
  end

endmodule

// File: tb/tb_l2_axi_bridge.sv
// Directed bench for l2_axi_bridge: table of single transactions plus hazard, stall and reset sequences.
module tb_l2_axi_bridge;

  localparam int OW = 3;
  localparam int LW = 32 * (1 << OW);

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   addr_r, addr_w;
  logic [LW-1:0] din_line;
  logic          req_r, req_w, rdy, suc;
  logic [3:0]    wstrb;
  logic [1:0]    size;
  logic          addrok_r, addrok_w, dataok;
  logic [LW-1:0] dout_line;
  logic [31:0]   araddr, rdata, awaddr, wdata;
  logic [7:0]    arlen, awlen;
  logic [2:0]    arsize, awsize;
  logic [1:0]    arburst, awburst;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]    wstrb_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l2_axi_bridge dut (
    .clk(clk), .rstn(rstn), .addr_r(addr_r), .addr_w(addr_w), .din_line(din_line),
    .req_r(req_r), .req_w(req_w), .rdy(rdy), .suc(suc), .wstrb(wstrb), .size(size),
    .addrok_r(addrok_r), .addrok_w(addrok_w), .dataok(dataok), .dout_line(dout_line),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb_o(wstrb_o), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    bit          wr;
    bit          s;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [3:0]  strb;
    logic [31:0] base;
    int          stall;
    int          gap;
    logic [31:0] ea;
    logic [7:0]  el;
    logic [2:0]  es;
    logic [3:0]  estrb;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] all_outs();
    return {addrok_r, addrok_w, dataok, dout_line, araddr, arlen, arsize, arburst, arvalid, rready,
            awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb_o, wlast, wvalid, bready};
  endfunction

  task automatic rd_accept(input logic [31:0] a, input logic s, input logic [1:0] sz,
                           input int budget, output int waited);
    addr_r = a; suc = s; size = sz; req_r = 1'b1; #1;
    waited = 0;
    while (!addrok_r && waited < budget) begin @(negedge clk); #1; waited++; end
    if (!addrok_r) waited = -1;
    @(negedge clk); req_r = 1'b0; suc = 1'b0; size = 2'd0; #1;
  endtask

  task automatic rd_finish(input logic [31:0] ea, input logic [7:0] el, input logic [2:0] es,
                           input int stall, input int gap, input logic [31:0] base);
    int n; logic ok; logic [LW-1:0] exp_line;
    n = 0;
    while (!arvalid && n < 20) begin @(negedge clk); #1; n++; end
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, ea);
    chk("arlen", arlen, el);
    chk("arsize", arsize, es);
    chk("arburst", arburst, 1);
    ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk); #1;
      if (arvalid !== 1'b1 || araddr !== ea || arlen !== el) ok = 1'b0;
    end
    if (stall > 0) chk("ar_stall_stable", ok, 1);
    arready = 1'b1; @(negedge clk); arready = 1'b0; #1;
    chk("rready", rready, 1);
    exp_line = '0;
    for (int k = 0; k <= int'(el); k++) begin
      repeat (gap) @(negedge clk);
      rdata = base + k; rlast = (k == int'(el)); rvalid = 1'b1;
      exp_line[k*32 +: 32] = base + k;
      @(negedge clk); rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0;
    end
    #1;
    chk("dataok_latency", dataok, 1);
    chk("dout_line", dout_line, exp_line);
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (dataok !== 1'b1 || dout_line !== exp_line) ok = 1'b0;
    end
    chk("dataok_hold", ok, 1);
    rdy = 1'b1; @(negedge clk); rdy = 1'b0; #1;
    chk("dataok_drop", dataok, 0);
  endtask

  task automatic wr_accept(input logic [31:0] a, input logic s, input logic [1:0] sz,
                           input logic [3:0] st, input logic [LW-1:0] line);
    addr_w = a; suc = s; size = sz; wstrb = st; din_line = line; req_w = 1'b1; #1;
    chk("addrok_w", addrok_w, 1);
    @(negedge clk);
    req_w = 1'b0; suc = 1'b0; size = 2'd0; wstrb = 4'd0; din_line = {8{32'hFFFF_0000}}; #1;
  endtask

  task automatic wr_finish(input logic [31:0] ea, input logic [7:0] el, input logic [2:0] es,
                           input logic [LW-1:0] line, input logic [3:0] estrb);
    int n;
    n = 0;
    while (!awvalid && n < 20) begin @(negedge clk); #1; n++; end
    chk("awvalid", awvalid, 1);
    chk("awaddr", awaddr, ea);
    chk("awlen", awlen, el);
    chk("awsize", awsize, es);
    chk("awburst", awburst, 1);
    chk("wvalid_before_aw", wvalid, 0);
    awready = 1'b1; @(negedge clk); awready = 1'b0; #1;
    for (int k = 0; k <= int'(el); k++) begin
      n = 0;
      while (!wvalid && n < 20) begin @(negedge clk); #1; n++; end
      chk("wvalid", wvalid, 1);
      chk("wdata", wdata, line[k*32 +: 32]);
      chk("wstrb_o", wstrb_o, estrb);
      chk("wlast", wlast, (k == int'(el)));
      wready = 1'b1; @(negedge clk); wready = 1'b0; #1;
    end
    n = 0;
    while (!bready && n < 20) begin @(negedge clk); #1; n++; end
    chk("bready", bready, 1);
  endtask

  task automatic b_done();
    bvalid = 1'b1; @(negedge clk); bvalid = 1'b0; #1;
    chk("w_idle_after_b", {bready, awvalid, wvalid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int w;
    logic [LW-1:0] line;

    vecs[0] = '{wr:0, s:0, a:32'h1C00_0044, sz:2'd2, strb:4'h0, base:32'h0, stall:0, gap:0,
                ea:32'h1C00_0040, el:8'd7, es:3'd2, estrb:4'h0};
    vecs[1] = '{wr:0, s:0, a:32'h0000_1234, sz:2'd2, strb:4'h0, base:32'h100, stall:5, gap:2,
                ea:32'h0000_1220, el:8'd7, es:3'd2, estrb:4'h0};
    vecs[2] = '{wr:0, s:1, a:32'hBFAF_8006, sz:2'd1, strb:4'h0, base:32'h1234_5678, stall:1, gap:1,
                ea:32'hBFAF_8006, el:8'd0, es:3'd1, estrb:4'h0};
    vecs[3] = '{wr:1, s:0, a:32'h0000_0100, sz:2'd2, strb:4'h0, base:32'hA0, stall:0, gap:0,
                ea:32'h0000_0100, el:8'd7, es:3'd2, estrb:4'hF};
    vecs[4] = '{wr:1, s:1, a:32'hBFAF_8002, sz:2'd0, strb:4'b0100, base:32'h00AB_0000, stall:0, gap:0,
                ea:32'hBFAF_8002, el:8'd0, es:3'd0, estrb:4'b0100};
    vecs[5] = '{wr:1, s:0, a:32'h0000_1ABC, sz:2'd2, strb:4'h3, base:32'h55, stall:0, gap:0,
                ea:32'h0000_1AA0, el:8'd7, es:3'd2, estrb:4'hF};

    rstn = 1'b0; addr_r = '0; addr_w = '0; din_line = '0; req_r = 1'b0; req_w = 1'b0;
    rdy = 1'b0; suc = 1'b0; wstrb = '0; size = '0; arready = 1'b0; rdata = '0;
    rlast = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", all_outs(), 0);
    rstn = 1'b1;
    @(negedge clk); #1;

    foreach (vecs[i]) begin
      if (!vecs[i].wr) begin
        rd_accept(vecs[i].a, vecs[i].s, vecs[i].sz, 10, w);
        chk("addrok_r_wait", w, 0);
        rd_finish(vecs[i].ea, vecs[i].el, vecs[i].es, vecs[i].stall, vecs[i].gap, vecs[i].base);
      end else begin
        for (int k = 0; k < 8; k++)
          line[k*32 +: 32] = (vecs[i].s && k > 0) ? (32'hDEAD_0000 | k) : (vecs[i].base + k);
        wr_accept(vecs[i].a, vecs[i].s, vecs[i].sz, vecs[i].strb, line);
        wr_finish(vecs[i].ea, vecs[i].el, vecs[i].es, line, vecs[i].estrb);
        b_done();
      end
    end

    // Write to line 0x100 parked behind a stalled AW; reads to other lines proceed.
    for (int k = 0; k < 8; k++) line[k*32 +: 32] = 32'hA0 + k;
    wr_accept(32'h0000_0100, 1'b0, 2'd2, 4'h0, line);
    rd_accept(32'h0000_0200, 1'b0, 2'd2, 3, w);
    chk("raw_other_line_wait", w, 0);
    rd_finish(32'h0000_0200, 8'd7, 3'd2, 0, 0, 32'h300);
    chk("aw_still_stalled", awvalid, 1);
    addr_r = 32'h0000_0104; req_r = 1'b1; #1;
`ifdef L2AXI_RAW_CHECK_EN
    chk("raw_blocked", addrok_r, 0);
    wr_finish(32'h0000_0100, 8'd7, 3'd2, line, 4'hF);
    chk("raw_blocked_in_b", addrok_r, 0);
    bvalid = 1'b1; #1;
    chk("raw_blocked_bvalid", addrok_r, 0);
    @(negedge clk); bvalid = 1'b0; #1;
    chk("raw_released", addrok_r, 1);
    @(negedge clk); req_r = 1'b0; #1;
    rd_finish(32'h0000_0100, 8'd7, 3'd2, 0, 0, 32'h400);
`else
    chk("raw_unchecked_accept", addrok_r, 1);
    @(negedge clk); req_r = 1'b0; #1;
    rd_finish(32'h0000_0100, 8'd7, 3'd2, 0, 0, 32'h400);
    wr_finish(32'h0000_0100, 8'd7, 3'd2, line, 4'hF);
    b_done();
`endif

    // Reset in the middle of a read burst, then a clean refill.
    rd_accept(32'h1C00_0080, 1'b0, 2'd2, 3, w);
    chk("pre_reset_accept_wait", w, 0);
    arready = 1'b1; @(negedge clk); arready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rdata = 32'hE0 + k; rvalid = 1'b1; @(negedge clk);
    end
    rvalid = 1'b0; rdata = '0; rstn = 1'b0;
    @(negedge clk); #1;
    chk("reset_mid_burst_outputs", all_outs(), 0);
    rstn = 1'b1;
    @(negedge clk); #1;
    rd_accept(32'h1C00_0080, 1'b0, 2'd2, 3, w);
    chk("post_reset_accept_wait", w, 0);
    rd_finish(32'h1C00_0080, 8'd7, 3'd2, 0, 0, 32'h50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
